// File: rtl/user_ddr3_pkg.sv
// Shared definitions for the DDR3 read/write test path: checker states and
// the single test-pattern definition used by both writer and checker.
`timescale 1ns/1ps
package user_ddr3_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2
    } chk_state_t;

    localparam int DEFAULT_FRAME_LEN = 1024;

    // Incrementing pattern: data = seed + step * beat_index (mod 2^width)
    localparam int PATTERN_SEED = 0;
    localparam int PATTERN_STEP = 1;

endpackage

// File: rtl/user_pattern_gen.sv
// Maps a beat index to the expected test data word. Shared by the write-side
// generator and the read checker so both follow one pattern definition.
`timescale 1ns/1ps
module user_pattern_gen
    import user_ddr3_pkg::*;
#(
    parameter int USER_DATA_WIDTH = 8,
    parameter int IDX_WIDTH       = 10
) (
    input  logic [IDX_WIDTH-1:0]       beat_idx,
    output logic [USER_DATA_WIDTH-1:0] exp_data
);

    // Width casts truncate or zero-extend the index, giving the mod-2^W wrap.
    assign exp_data = USER_DATA_WIDTH'(beat_idx) * USER_DATA_WIDTH'(PATTERN_STEP)
                    + USER_DATA_WIDTH'(PATTERN_SEED);

endmodule

// File: rtl/user_rd_data_check.sv
// Read-data checker: compares each returned beat against the incrementing
// test pattern and reports a per-frame verdict, error count and first-error index.
//
// state | meaning
// IDLE  | waiting for chk_start with controller calibrated; beats here are stray
// CHECK | comparing valid beats, beat_idx advances per valid beat
// DONE  | single cycle, chk_done pulse, verdict final
`timescale 1ns/1ps
module user_rd_data_check
    import user_ddr3_pkg::*;
#(
    parameter int USER_DATA_WIDTH = 8,
    parameter int FRAME_LEN       = DEFAULT_FRAME_LEN,
    parameter int ERR_CNT_WIDTH   = 16,
    localparam int IDX_W          = $clog2(FRAME_LEN)
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst,
    input  logic                       ddrc_init_done,
    input  logic                       chk_start,
    input  logic [USER_DATA_WIDTH-1:0] user_rd_data,
    input  logic                       user_rd_data_valid,
    output logic                       chk_busy,
    output logic                       chk_done,
    output logic                       chk_pass,
    output logic [ERR_CNT_WIDTH-1:0]   chk_err_cnt,
    output logic [IDX_W-1:0]           chk_first_err_idx,
    output logic                       chk_stray
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    chk_state_t                 state, state_nxt;
    logic [IDX_W-1:0]           beat_idx, beat_idx_nxt;
    logic [ERR_CNT_WIDTH-1:0]   err_cnt_nxt;
    logic [IDX_W-1:0]           first_idx_nxt;
    logic                       first_seen, first_seen_nxt;
    logic                       pass_nxt;
    logic                       stray_nxt;
    logic [USER_DATA_WIDTH-1:0] exp_data;
    logic                       mismatch;

    user_pattern_gen #(
        .USER_DATA_WIDTH (USER_DATA_WIDTH),
        .IDX_WIDTH       (IDX_W)
    ) u_pattern_gen (
        .beat_idx (beat_idx),
        .exp_data (exp_data)
    );

    assign mismatch = (user_rd_data != exp_data);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        beat_idx_nxt   = beat_idx;
        err_cnt_nxt    = chk_err_cnt;
        first_idx_nxt  = chk_first_err_idx;
        first_seen_nxt = first_seen;
        pass_nxt       = chk_pass;
        stray_nxt      = chk_stray;
        chk_busy       = 1'b0;
        chk_done       = 1'b0;

        case (state)
            IDLE: begin
                if (chk_start && ddrc_init_done) begin
                    state_nxt      = CHECK;
                    beat_idx_nxt   = '0;
                    err_cnt_nxt    = '0;
                    first_idx_nxt  = '0;
                    first_seen_nxt = 1'b0;
                    pass_nxt       = 1'b0;
                    // A beat coinciding with the accepted start is not checked.
                    stray_nxt      = user_rd_data_valid;
                end else if (user_rd_data_valid) begin
                    stray_nxt = 1'b1;
                end
            end

            CHECK: begin
                chk_busy = 1'b1;
                if (!ddrc_init_done) begin
                    state_nxt = IDLE;
                    pass_nxt  = 1'b0;
                end else if (user_rd_data_valid) begin
                    beat_idx_nxt = beat_idx + 1'b1;
                    if (mismatch) begin
                        if (chk_err_cnt != '1) begin
                            err_cnt_nxt = chk_err_cnt + 1'b1;
                        end
                        if (!first_seen) begin
                            first_seen_nxt = 1'b1;
                            first_idx_nxt  = beat_idx;
                        end
                    end
                    if (beat_idx == LAST_IDX) begin
                        state_nxt = DONE;
                        pass_nxt  = (err_cnt_nxt == '0);
                    end
                end
            end

            DONE: begin
                chk_done  = 1'b1;
                state_nxt = IDLE;
                if (user_rd_data_valid) begin
                    stray_nxt = 1'b1;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            beat_idx          <= '0;
            chk_err_cnt       <= '0;
            chk_first_err_idx <= '0;
            first_seen        <= 1'b0;
            chk_pass          <= 1'b0;
            chk_stray         <= 1'b0;
        end else begin
            beat_idx          <= beat_idx_nxt;
            chk_err_cnt       <= err_cnt_nxt;
            chk_first_err_idx <= first_idx_nxt;
            first_seen        <= first_seen_nxt;
            chk_pass          <= pass_nxt;
            chk_stray         <= stray_nxt;
        end
    end

endmodule

// File: tb/tb_user_rd_data_check.sv
// Directed bench for user_rd_data_check: frame verdicts via a scoreboard queue,
// plus abort, stray, reset and saturation cases on a small second instance.
`timescale 1ns/1ps
module tb_user_rd_data_check;

    localparam int FRAME = 1024;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;

    logic        ddrc_init_done;
    logic        chk_start;
    logic [7:0]  user_rd_data;
    logic        user_rd_data_valid;
    logic        chk_busy;
    logic        chk_done;
    logic        chk_pass;
    logic [15:0] chk_err_cnt;
    logic [9:0]  chk_first_err_idx;
    logic        chk_stray;

    logic        s_init_done;
    logic        s_start;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_busy;
    logic        s_done;
    logic        s_pass;
    logic [3:0]  s_err_cnt;
    logic [4:0]  s_first;
    logic        s_stray;

    user_rd_data_check u_dut (
        .sys_clk            (sys_clk),
        .sys_rst            (sys_rst),
        .ddrc_init_done     (ddrc_init_done),
        .chk_start          (chk_start),
        .user_rd_data       (user_rd_data),
        .user_rd_data_valid (user_rd_data_valid),
        .chk_busy           (chk_busy),
        .chk_done           (chk_done),
        .chk_pass           (chk_pass),
        .chk_err_cnt        (chk_err_cnt),
        .chk_first_err_idx  (chk_first_err_idx),
        .chk_stray          (chk_stray)
    );

    user_rd_data_check #(
        .USER_DATA_WIDTH (8),
        .FRAME_LEN       (32),
        .ERR_CNT_WIDTH   (4)
    ) u_sat (
        .sys_clk            (sys_clk),
        .sys_rst            (sys_rst),
        .ddrc_init_done     (s_init_done),
        .chk_start          (s_start),
        .user_rd_data       (s_data),
        .user_rd_data_valid (s_valid),
        .chk_busy           (s_busy),
        .chk_done           (s_done),
        .chk_pass           (s_pass),
        .chk_err_cnt        (s_err_cnt),
        .chk_first_err_idx  (s_first),
        .chk_stray          (s_stray)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [15:0] err;
        logic [9:0]  first;
        logic        pass;
    } exp_t;

    int   vectors     = 0;
    int   miscompares = 0;
    int   done_cnt    = 0;
    int   busy_low    = 0;
    int   done_before = 0;
    exp_t exp_q[$];
    logic [7:0] frame_data [FRAME];

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Builds the beat stream and pushes the frame verdict the model predicts.
    task automatic build_frame(input int bad0, input logic [7:0] val0,
                               input int bad1, input logic [7:0] val1);
        exp_t e;
        e.err   = '0;
        e.first = '0;
        for (int i = 0; i < FRAME; i++) begin
            frame_data[i] = 8'(i);
            if (i == bad0) frame_data[i] = val0;
            if (i == bad1) frame_data[i] = val1;
        end
        for (int i = 0; i < FRAME; i++) begin
            if (frame_data[i] != 8'(i)) begin
                if (e.err == 0) e.first = 10'(i);
                e.err = e.err + 16'd1;
            end
        end
        e.pass = (e.err == 0);
        exp_q.push_back(e);
    endtask

    task automatic start_frame();
        chk_start = 1'b1;
        step();
        chk_start = 1'b0;
    endtask

    task automatic drive_frame(input int max_gap, input int restart_at);
        busy_low = 0;
        for (int i = 0; i < FRAME; i++) begin
            int gap;
            gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            repeat (gap) begin
                user_rd_data_valid = 1'b0;
                chk_start          = 1'b0;
                step();
                if (chk_busy !== 1'b1) busy_low++;
            end
            user_rd_data       = frame_data[i];
            user_rd_data_valid = 1'b1;
            chk_start          = (i == restart_at);
            step();
            if (i < FRAME - 1 && chk_busy !== 1'b1) busy_low++;
        end
        user_rd_data_valid = 1'b0;
        chk_start          = 1'b0;
    endtask

    // Scoreboard: every chk_done pulse retires one predicted frame verdict.
    always @(negedge sys_clk) begin
        if (!sys_rst && chk_done === 1'b1) begin
            exp_t e;
            done_cnt++;
            check("done_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("sb_err_cnt", 32'(chk_err_cnt), 32'(e.err));
                check("sb_first_idx", 32'(chk_first_err_idx), 32'(e.first));
                check("sb_pass", 32'(chk_pass), 32'(e.pass));
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        ddrc_init_done     = 1'b1;
        chk_start          = 1'b0;
        user_rd_data       = '0;
        user_rd_data_valid = 1'b0;
        s_init_done        = 1'b1;
        s_start            = 1'b0;
        s_data             = '0;
        s_valid            = 1'b0;

        // Reset values
        sys_rst = 1'b1;
        repeat (3) step();
        sys_rst = 1'b0;
        step();
        check("rst_busy", 32'(chk_busy), 32'd0);
        check("rst_done", 32'(chk_done), 32'd0);
        check("rst_pass", 32'(chk_pass), 32'd0);
        check("rst_err_cnt", 32'(chk_err_cnt), 32'd0);
        check("rst_first_idx", 32'(chk_first_err_idx), 32'd0);
        check("rst_stray", 32'(chk_stray), 32'd0);
        check("rst_sat_err_cnt", 32'(s_err_cnt), 32'd0);

        // Clean contiguous frame
        build_frame(-1, 8'h00, -1, 8'h00);
        start_frame();
        check("t1_busy_after_start", 32'(chk_busy), 32'd1);
        drive_frame(0, -1);
        check("t1_done", 32'(chk_done), 32'd1);
        check("t1_busy_in_done", 32'(chk_busy), 32'd0);
        check("t1_pass", 32'(chk_pass), 32'd1);
        check("t1_err_cnt", 32'(chk_err_cnt), 32'd0);
        check("t1_busy_low", 32'(busy_low), 32'd0);
        step();
        check("t1_done_one_cycle", 32'(chk_done), 32'd0);
        check("t1_pass_held", 32'(chk_pass), 32'd1);

        // Two corrupted beats; a start mid-frame must be ignored
        build_frame(5, 8'hAA, 700, 8'h00);
        start_frame();
        drive_frame(0, 600);
        check("t2_done", 32'(chk_done), 32'd1);
        check("t2_err_cnt", 32'(chk_err_cnt), 32'd2);
        check("t2_first_idx", 32'(chk_first_err_idx), 32'd5);
        check("t2_pass", 32'(chk_pass), 32'd0);
        step();

        // Clean frame with random valid gaps
        build_frame(-1, 8'h00, -1, 8'h00);
        done_before = done_cnt;
        start_frame();
        drive_frame(3, -1);
        check("t3_done", 32'(chk_done), 32'd1);
        check("t3_busy_low", 32'(busy_low), 32'd0);
        repeat (4) step();
        check("t3_done_count", 32'(done_cnt - done_before), 32'd1);
        check("t3_pass", 32'(chk_pass), 32'd1);

        // Start without calibration is ignored; beats are stray
        check("t4_stray_before", 32'(chk_stray), 32'd0);
        done_before    = done_cnt;
        ddrc_init_done = 1'b0;
        start_frame();
        check("t4_busy_after_start", 32'(chk_busy), 32'd0);
        for (int i = 0; i < 10; i++) begin
            user_rd_data       = 8'(i);
            user_rd_data_valid = 1'b1;
            step();
        end
        user_rd_data_valid = 1'b0;
        step();
        check("t4_busy", 32'(chk_busy), 32'd0);
        check("t4_stray", 32'(chk_stray), 32'd1);
        check("t4_no_done", 32'(done_cnt - done_before), 32'd0);

        // Start with a coincident stray beat, then abort after 300 beats
        ddrc_init_done     = 1'b1;
        chk_start          = 1'b1;
        user_rd_data       = 8'h55;
        user_rd_data_valid = 1'b1;
        step();
        chk_start          = 1'b0;
        user_rd_data_valid = 1'b0;
        check("t5_busy", 32'(chk_busy), 32'd1);
        check("t5_stray_on_start", 32'(chk_stray), 32'd1);
        check("t5_err_after_start", 32'(chk_err_cnt), 32'd0);
        check("t5_pass_cleared", 32'(chk_pass), 32'd0);
        for (int i = 0; i < 300; i++) begin
            user_rd_data       = (i == 100) ? 8'hFF : 8'(i);
            user_rd_data_valid = 1'b1;
            step();
            if (i == 99) check("t5_err_before_bad", 32'(chk_err_cnt), 32'd0);
            if (i == 100) begin
                check("t5_err_latency", 32'(chk_err_cnt), 32'd1);
                check("t5_first_latency", 32'(chk_first_err_idx), 32'd100);
            end
        end
        user_rd_data_valid = 1'b0;
        ddrc_init_done     = 1'b0;
        step();
        check("t5_abort_busy", 32'(chk_busy), 32'd0);
        check("t5_abort_done", 32'(chk_done), 32'd0);
        check("t5_abort_pass", 32'(chk_pass), 32'd0);
        check("t5_abort_err_hold", 32'(chk_err_cnt), 32'd1);
        check("t5_abort_first_hold", 32'(chk_first_err_idx), 32'd100);
        ddrc_init_done = 1'b1;
        repeat (3) step();
        check("t5_abort_no_done", 32'(done_cnt - done_before), 32'd0);

        // Synchronous reset in the middle of a frame
        chk_start          = 1'b1;
        user_rd_data       = 8'h00;
        user_rd_data_valid = 1'b1;
        step();
        chk_start = 1'b0;
        for (int i = 0; i < 50; i++) begin
            user_rd_data       = (i == 3) ? 8'h77 : 8'(i);
            user_rd_data_valid = 1'b1;
            step();
        end
        check("t5_pre_rst_err", 32'(chk_err_cnt), 32'd1);
        sys_rst = 1'b1;
        step();
        sys_rst            = 1'b0;
        user_rd_data_valid = 1'b0;
        check("t5_rst_busy", 32'(chk_busy), 32'd0);
        check("t5_rst_done", 32'(chk_done), 32'd0);
        check("t5_rst_pass", 32'(chk_pass), 32'd0);
        check("t5_rst_err_cnt", 32'(chk_err_cnt), 32'd0);
        check("t5_rst_first_idx", 32'(chk_first_err_idx), 32'd0);
        check("t5_rst_stray", 32'(chk_stray), 32'd0);
        repeat (3) step();
        check("t5_rst_no_done", 32'(done_cnt - done_before), 32'd0);

        // Saturation: 4-bit counter, 32-beat frame, every beat wrong
        s_start = 1'b1;
        step();
        s_start = 1'b0;
        check("t6_busy", 32'(s_busy), 32'd1);
        for (int i = 0; i < 32; i++) begin
            s_data  = 8'(i) ^ 8'hFF;
            s_valid = 1'b1;
            step();
            if (i == 13) check("t6_err_14", 32'(s_err_cnt), 32'd14);
            if (i == 14) check("t6_err_15", 32'(s_err_cnt), 32'd15);
            if (i == 20) check("t6_err_sat", 32'(s_err_cnt), 32'd15);
        end
        s_valid = 1'b0;
        check("t6_done", 32'(s_done), 32'd1);
        check("t6_err_final", 32'(s_err_cnt), 32'd15);
        check("t6_first_idx", 32'(s_first), 32'd0);
        check("t6_pass", 32'(s_pass), 32'd0);
        check("t6_stray", 32'(s_stray), 32'd0);
        step();
        check("t6_done_cleared", 32'(s_done), 32'd0);

        check("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
